regfile_dump_unit: RTL and testbench
====================================

REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

Interface
- REQ-001: Parameter NUM_REGS, default 32, is the number of registers dumped, indices 0..NUM_REGS-1; legal range 1..32.
- REQ-002: clk  input  1  single clock; all state changes on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: start  input  1  one-cycle request to begin a dump.
- REQ-005: alive  input  1  CPU running flag; a dump is legal only while alive=0.
- REQ-006: mau_clk_en  output  1  register-file MAU-port clock enable.
- REQ-007: mau_address  output  32  register byte address, {25'b0, index[4:0], 2'b00}.
- REQ-008: mau_wren  output  1  MAU write enable; tied to 0.
- REQ-009: mau_data_write  output  32  MAU write data; tied to 0.
- REQ-010: rf_data_read  input  32  port-0 read data; valid one clk after an address is presented with mau_clk_en=1.
- REQ-011: out_valid  output  1  out_data, out_index and out_last are valid.
- REQ-012: out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
- REQ-013: out_data  output  32  register contents.
- REQ-014: out_index  output  5  register number of out_data.
- REQ-015: out_last  output  1  high with the word for index NUM_REGS-1.
- REQ-016: busy  output  1  high in every state except IDLE.
- REQ-017: done  output  1  one-cycle pulse when the last word is accepted.
- REQ-018: error  output  1  one-cycle pulse on a rejected start or an abort.

Function
- REQ-019: FSM states are IDLE, ISSUE, CAPTURE and SEND.
- REQ-020: In IDLE, start=1 with alive=0 SHALL clear index to 0 and go to ISSUE; start=1 with alive=1 SHALL pulse error and stay in IDLE.
- REQ-021: In ISSUE, the block SHALL drive mau_address from index with mau_clk_en=1 for exactly one cycle, then go to CAPTURE.
- REQ-022: In CAPTURE, mau_clk_en=0; the block SHALL register rf_data_read into out_data and index into out_index, set out_valid=1 and go to SEND.
- REQ-023: In SEND, out_data, out_index, out_last and out_valid SHALL hold stable until out_ready=1.
- REQ-024: On acceptance in SEND: if index=NUM_REGS-1, clear out_valid, pulse done and go to IDLE; otherwise clear out_valid, increment index and go to ISSUE.
- REQ-025: Minimum throughput is one word per 3 cycles; latency from start to the first out_valid is 2 cycles.
- REQ-026: mau_clk_en SHALL be 0 in IDLE, CAPTURE and SEND; mau_wren SHALL never assert.
- REQ-027: If alive=1 in any non-IDLE state, the block SHALL clear out_valid, pulse error and go to IDLE the next cycle, with no done pulse. This takes priority over a simultaneous handshake.
- REQ-028: start SHALL be ignored while busy=1.
- REQ-029: Register 31 is passed through as returned by the register file, which reads as 0; the block SHALL NOT special-case it.
- REQ-030: index SHALL never wrap past NUM_REGS-1.

Reset
- REQ-031: While reset=1, the following SHALL be 0 immediately and asynchronously: state=IDLE, index, out_valid, out_data, out_index, out_last, busy, done, error, mau_clk_en and mau_address.
- REQ-032: A reset in the middle of a dump SHALL abandon it, with no done or error pulse.

Verification
- REQ-033: alive=0, out_ready=1, start, register-file model holding reg[i]=0x100+i (reg31 reads 0) -> 32 words in index order 0..31 with data 0x100..0x11E then 0; out_last only on index 31; done one cycle after index 31 is accepted; 96 cycles in total.
- REQ-034: Hold out_ready=0 for 5 cycles while the word for index 3 is valid -> out_data=0x103 and out_index=3 stay stable, mau_clk_en=0 throughout, and the next word is index 4.
- REQ-035: start while alive=1 -> error pulses once, busy stays 0, mau_clk_en stays 0.
- REQ-036: Raise alive during the word for index 10 while out_ready=1 -> error pulses, no done, busy=0 the next cycle, and no further out_valid.
- REQ-037: Assert reset during the word for index 7 -> all outputs 0 at once; a new start after reset is released restarts from index 0.
- REQ-038: With NUM_REGS=1, start -> exactly one word, index 0, out_last=1, followed by done.

Source files
------------

// File: rtl/regfile_dump_unit_if.sv
// Bus bundle between the register-file dump unit, the register file's MAU
// port and the downstream word sink.
//   master : dump unit side (drives MAU request and output stream)
//   slave  : register file / sink side
// Ports carried:
//   mau_clk_en, mau_address, mau_wren, mau_data_write : MAU request
//   rf_data_read                                      : port-0 read data
//   out_valid, out_ready, out_data, out_index, out_last : output stream
//
// Output stream handshake: a word transfers on a rising clk edge where
// out_valid=1 and out_ready=1. Once out_valid is raised, out_data, out_index
// and out_last hold stable until that transfer happens. The only other way
// out_valid falls is an abort or reset. out_ready may change freely.
interface regfile_dump_unit_if;
    logic        mau_clk_en;
    logic [31:0] mau_address;
    logic        mau_wren;
    logic [31:0] mau_data_write;
    logic [31:0] rf_data_read;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;

    modport master (
        output mau_clk_en,
        output mau_address,
        output mau_wren,
        output mau_data_write,
        input  rf_data_read,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  mau_clk_en,
        input  mau_address,
        input  mau_wren,
        input  mau_data_write,
        output rf_data_read,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_unit.sv
// Register-file dump unit: while the CPU is halted (alive=0), reads
// registers 0..NUM_REGS-1 through the register file's MAU port and streams
// them out one word at a time with a valid/ready handshake.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle dump request (ignored while busy)
//   alive      : CPU running flag; rejects a start, aborts a running dump
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse after the last word is accepted
//   error      : one-cycle pulse on a rejected start or an abort
//   state_dbg  : current FSM state (IDLE=0, ISSUE=1, CAPTURE=2, SEND=3)
//   bus        : MAU port and output stream (see regfile_dump_unit_if)
module regfile_dump_unit #(
    parameter int NUM_REGS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       alive,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [1:0]                 state_dbg,
    regfile_dump_unit_if.master        bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t     state;
    state_t     next_state;
    logic [4:0] index;
    logic       is_last;
    logic       clear_index;
    logic       load_word;
    logic       accept;
    logic       abort;
    logic       set_done;
    logic       set_error;

    assign is_last = (index == LAST_IDX);

    // Next state and one-cycle control strobes for the datapath.
    always_comb begin
        next_state  = state;
        clear_index = 1'b0;
        load_word   = 1'b0;
        accept      = 1'b0;
        abort       = 1'b0;
        set_done    = 1'b0;
        set_error   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (alive) begin
                        set_error = 1'b1;
                    end else begin
                        clear_index = 1'b1;
                        next_state  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                load_word  = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (is_last) begin
                        set_done   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // CPU restarted mid-dump: the abort wins over any handshake this cycle.
        if (state != IDLE && alive) begin
            next_state = IDLE;
            load_word  = 1'b0;
            accept     = 1'b0;
            set_done   = 1'b0;
            abort      = 1'b1;
            set_error  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index         <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_index <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            done  <= set_done;
            error <= set_error;

            // The last index is never incremented, so index cannot wrap.
            if (clear_index) begin
                index <= '0;
            end else if (accept && !is_last) begin
                index <= index + 5'd1;
            end

            // Read data arrives one cycle after the ISSUE cycle, i.e. in CAPTURE.
            if (load_word) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.rf_data_read;
                bus.out_index <= index;
                bus.out_last  <= is_last;
            end else if (accept || abort) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // The MAU port is only clocked in ISSUE; the address follows index.
    assign bus.mau_clk_en     = (state == ISSUE);
    assign bus.mau_address    = {25'b0, index, 2'b00};
    assign bus.mau_wren       = 1'b0;
    assign bus.mau_data_write = 32'b0;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;
    localparam int N = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic alive = 1'b0;
    logic busy;
    logic done;
    logic error;
    logic [1:0] state_dbg;

    logic start1 = 1'b0;
    logic alive1 = 1'b0;
    logic busy1;
    logic done1;
    logic error1;
    logic [1:0] state_dbg1;

    always #5 clk = ~clk;

    regfile_dump_unit_if bus();
    regfile_dump_unit_if bus1();

    regfile_dump_unit #(.NUM_REGS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .alive(alive),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg),
        .bus(bus)
    );

    regfile_dump_unit #(.NUM_REGS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .alive(alive1),
        .busy(busy1), .done(done1), .error(error1), .state_dbg(state_dbg1),
        .bus(bus1)
    );

    // Register file model: synchronous read on the MAU port.
    logic [31:0] regs [32];

    always @(posedge clk) begin
        if (bus.mau_clk_en) bus.rf_data_read <= regs[bus.mau_address[6:2]];
        if (bus1.mau_clk_en) bus1.rf_data_read <= regs[bus1.mau_address[6:2]];
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  exp_q[$];       // indices still to be delivered in this dump
    logic [31:0] acc_data_q[$];  // data of accepted words, for literal checks
    logic        m_busy    = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_error = 1'b0;
    int          word_wait = 0;
    bit          word_seen = 1'b0;
    int          busy_cycles = 0;
    int          error_cnt = 0;
    int          done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- compare process (every falling edge) ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_busy    = 1'b0;
            exp_done  = 1'b0;
            exp_error = 1'b0;
            word_wait = 0;
            word_seen = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_valid", bus.out_valid, 0);
            check("rst_clk_en", bus.mau_clk_en, 0);
        end else begin
            if (busy) busy_cycles++;
            if (error) error_cnt++;
            if (done) done_cnt++;
            check("done", done, exp_done);
            check("error", error, exp_error);
            check("busy", busy, m_busy);
            check("wren", bus.mau_wren, 0);
            check("wdata", bus.mau_data_write, 0);

            if (!m_busy) begin
                check("valid_idle", bus.out_valid, 0);
                check("clk_en_idle", bus.mau_clk_en, 0);
            end else if (exp_q.size() == 0) begin
                check("model_queue_empty", 1, 0);
            end else if (!bus.out_valid) begin
                // First cycle of each word presents the address; the next waits.
                check("clk_en", bus.mau_clk_en, (word_wait == 0));
                if (word_wait == 0) check("addr", bus.mau_address, {25'b0, exp_q[0], 2'b00});
                word_wait++;
            end else begin
                if (!word_seen) begin
                    check("word_latency", word_wait, 2);
                    word_seen = 1'b1;
                end
                check("clk_en_send", bus.mau_clk_en, 0);
                check("out_index", bus.out_index, exp_q[0]);
                check("out_data", bus.out_data, regs[exp_q[0]]);
                check("out_last", bus.out_last, (exp_q[0] == 5'(N - 1)));
            end

            // Predict the effect of the coming rising edge.
            exp_done  = 1'b0;
            exp_error = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    if (alive) begin
                        exp_error = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        exp_q.delete();
                        for (int i = 0; i < N; i++) exp_q.push_back(5'(i));
                        word_wait = 0;
                        word_seen = 1'b0;
                    end
                end
            end else if (alive) begin
                exp_error = 1'b1;
                m_busy    = 1'b0;
                exp_q.delete();
            end else if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                acc_data_q.push_back(bus.out_data);
                void'(exp_q.pop_front());
                word_wait = 0;
                word_seen = 1'b0;
                if (exp_q.size() == 0) begin
                    m_busy   = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_within_bound", ok, 1);
    endtask

    task automatic wait_valid_idx(input logic [4:0] idx, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.out_valid && bus.out_index == idx) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("valid_idx_within_bound", ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_state"}, state_dbg, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_index"}, bus.out_index, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_clk_en"}, bus.mau_clk_en, 0);
        check({tag, "_addr"}, bus.mau_address, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        bit seen;
        bus.out_ready  = 1'b0;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        regs[31] = 32'h0;

        // Reset state, before any clock edge.
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Full dump with the sink always ready.
        bus.out_ready = 1'b1;
        busy_cycles = 0;
        done_cnt = 0;
        acc_data_q.delete();
        pulse_start();
        wait_done(200);
        step();
        check("full_busy_cycles", busy_cycles, 96);
        check("full_words", acc_data_q.size(), 32);
        check("full_done_cnt", done_cnt, 1);
        if (acc_data_q.size() == 32) begin
            check("full_word0", acc_data_q[0], 32'h100);
            check("full_word30", acc_data_q[30], 32'h11E);
            check("full_word31", acc_data_q[31], 32'h0);
        end

        // Back-pressure on index 3.
        pulse_start();
        wait_valid_idx(5'd3, 40);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, 32'h103);
            check("stall_index", bus.out_index, 3);
            check("stall_clk_en", bus.mau_clk_en, 0);
        end
        bus.out_ready = 1'b1;
        step();
        wait_valid_idx(5'd4, 10);
        check("after_stall_index", bus.out_index, 4);
        wait_done(200);
        step();

        // Start rejected while the CPU runs.
        error_cnt = 0;
        alive = 1'b1;
        pulse_start();
        check("reject_error", error, 1);
        check("reject_busy", busy, 0);
        check("reject_clk_en", bus.mau_clk_en, 0);
        step();
        check("reject_error_once", error, 0);
        check("reject_busy_after", busy, 0);
        check("reject_error_cnt", error_cnt, 1);
        alive = 1'b0;
        step();

        // Abort during the word for index 10 with the sink ready.
        done_cnt = 0;
        pulse_start();
        wait_valid_idx(5'd10, 60);
        alive = 1'b1;
        step();
        alive = 1'b0;
        check("abort_error", error, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_done", done, 0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.out_valid || done) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);
        check("abort_done_cnt", done_cnt, 0);

        // Reset in the middle of the word for index 7.
        pulse_start();
        wait_valid_idx(5'd7, 40);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        step();
        step();
        reset = 1'b0;
        step();
        check_all_zero("post_reset");
        pulse_start();
        wait_valid_idx(5'd0, 10);
        check("restart_index", bus.out_index, 0);
        check("restart_data", bus.out_data, 32'h100);
        wait_done(200);
        step();

        // Randomised phase: random contents, ready, starts and aborts.
        for (int i = 0; i < 31; i++) regs[i] = $urandom;
        regs[31] = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 11) == 0);
            alive = ($urandom_range(0, 249) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        start = 1'b0;
        alive = 1'b0;
        bus.out_ready = 1'b1;
        repeat (120) step();
        check("random_idle_at_end", busy, 0);

        // Single-register configuration.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_clk_en", bus1.mau_clk_en, 1);
        step();
        check("n1_capture_valid", bus1.out_valid, 0);
        step();
        check("n1_valid", bus1.out_valid, 1);
        check("n1_index", bus1.out_index, 0);
        check("n1_last", bus1.out_last, 1);
        check("n1_data", bus1.out_data, regs[0]);
        step();
        check("n1_done", done1, 1);
        check("n1_valid_after", bus1.out_valid, 0);
        check("n1_busy_after", busy1, 0);
        step();
        check("n1_done_once", done1, 0);
        check("n1_error", error1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
